// File: rtl/hd44780_byte_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hd44780_byte_tx_pkg : shared encodings, command codes and timing defaults  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package hd44780_byte_tx_pkg;

    localparam int unsigned c_DB_W  = 4;
    localparam int unsigned c_CNT_W = 20;

    localparam logic [7:0] c_CMD_CLEAR = 8'h01;
    localparam logic [7:0] c_CMD_HOME  = 8'h02;

    localparam int unsigned c_DEF_T_SETUP = 2;
    localparam int unsigned c_DEF_T_EPW   = 12;
    localparam int unsigned c_DEF_T_HOLD  = 2;
    localparam int unsigned c_DEF_T_GAP   = 2;
    localparam int unsigned c_DEF_T_WAIT  = 2000;
    localparam int unsigned c_DEF_T_LONG  = 82000;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SETUP_H = 4'd1,
        ST_EHI_H   = 4'd2,
        ST_HOLD_H  = 4'd3,
        ST_GAP     = 4'd4,
        ST_SETUP_L = 4'd5,
        ST_EHI_L   = 4'd6,
        ST_HOLD_L  = 4'd7,
        ST_WAIT    = 4'd8
    } state_t;

    // 0x03 shares the clear/home execution time on the controller.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == c_CMD_CLEAR) || (data == c_CMD_HOME) || (data == 8'h03));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hd44780_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hd44780_delay : loadable down-counter, o_done high while the count is 1    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hd44780_delay
    import hd44780_byte_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [c_CNT_W-1:0] i_value,
    output logic               o_done
);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == c_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/hd44780_byte_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hd44780_byte_tx : HD44780 4-bit byte transmitter (E strobe + exec wait)    |
// | Option macro HD44780_LONG_CMD_DELAY_EN: T_LONG wait for clear/home cmds.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hd44780_byte_tx
    import hd44780_byte_tx_pkg::*;
#(
    parameter int unsigned T_SETUP = c_DEF_T_SETUP,
    parameter int unsigned T_EPW   = c_DEF_T_EPW,
    parameter int unsigned T_HOLD  = c_DEF_T_HOLD,
    parameter int unsigned T_GAP   = c_DEF_T_GAP,
    parameter int unsigned T_WAIT  = c_DEF_T_WAIT,
    parameter int unsigned T_LONG  = c_DEF_T_LONG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_rs,
    input  logic              in_nibble_only,
    output logic              e,
    output logic              rs,
    output logic [c_DB_W-1:0] db,
    output logic              busy
);

    generate
        if ((T_SETUP < 1) || (T_SETUP > 255) || (T_EPW < 1) || (T_EPW > 255) ||
            (T_HOLD < 1) || (T_HOLD > 255) || (T_GAP < 1) || (T_GAP > 255) ||
            (T_WAIT < 1) || (T_WAIT >= (1 << c_CNT_W)) ||
            (T_LONG < 1) || (T_LONG >= (1 << c_CNT_W))) begin : g_bad_param
            $error("hd44780_byte_tx: timing parameter out of legal range");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nx;
    logic                w_load;
    logic [c_CNT_W-1:0]  w_load_val;
    logic [c_CNT_W-1:0]  w_wait_len;
    logic                w_done;
    logic                w_accept;

    logic                r_e;
    logic                r_rs;
    logic [c_DB_W-1:0]   r_db;
    logic [c_DB_W-1:0]   r_lo;
    logic                r_nib;

`ifdef HD44780_LONG_CMD_DELAY_EN
    logic                r_long;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_long <= 1'b0;
        end else if (w_accept) begin
            r_long <= is_long_cmd(in_rs, in_data);
        end
    end

    assign w_wait_len = r_long ? c_CNT_W'(T_LONG) : c_CNT_W'(T_WAIT);
`else
    assign w_wait_len = c_CNT_W'(T_WAIT);
`endif

    assign w_accept = (r_state == ST_IDLE) && in_valid;

    hd44780_delay u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Every state transition reloads the shared counter with the next duration.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        unique case (r_state)
            ST_IDLE: if (in_valid) begin
                w_state_nx = ST_SETUP_H; w_load = 1'b1; w_load_val = c_CNT_W'(T_SETUP);
            end
            ST_SETUP_H: if (w_done) begin
                w_state_nx = ST_EHI_H; w_load = 1'b1; w_load_val = c_CNT_W'(T_EPW);
            end
            ST_EHI_H: if (w_done) begin
                w_state_nx = ST_HOLD_H; w_load = 1'b1; w_load_val = c_CNT_W'(T_HOLD);
            end
            ST_HOLD_H: if (w_done) begin
                w_load = 1'b1;
                if (r_nib) begin
                    w_state_nx = ST_WAIT; w_load_val = w_wait_len;
                end else begin
                    w_state_nx = ST_GAP;  w_load_val = c_CNT_W'(T_GAP);
                end
            end
            ST_GAP: if (w_done) begin
                w_state_nx = ST_SETUP_L; w_load = 1'b1; w_load_val = c_CNT_W'(T_SETUP);
            end
            ST_SETUP_L: if (w_done) begin
                w_state_nx = ST_EHI_L; w_load = 1'b1; w_load_val = c_CNT_W'(T_EPW);
            end
            ST_EHI_L: if (w_done) begin
                w_state_nx = ST_HOLD_L; w_load = 1'b1; w_load_val = c_CNT_W'(T_HOLD);
            end
            ST_HOLD_L: if (w_done) begin
                w_state_nx = ST_WAIT; w_load = 1'b1; w_load_val = w_wait_len;
            end
            ST_WAIT: if (w_done) begin
                w_state_nx = ST_IDLE; w_load = 1'b1; w_load_val = '0;
            end
            default: begin
                w_state_nx = ST_IDLE; w_load = 1'b1; w_load_val = '0;
            end
        endcase
    end

    // Pin outputs are registered off the next state so E tracks the state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e   <= 1'b0;
            r_rs  <= 1'b0;
            r_db  <= '0;
            r_lo  <= '0;
            r_nib <= 1'b0;
        end else begin
            r_e <= (w_state_nx == ST_EHI_H) || (w_state_nx == ST_EHI_L);
            if (w_accept) begin
                r_rs  <= in_rs;
                r_db  <= in_data[7:4];
                r_lo  <= in_data[3:0];
                r_nib <= in_nibble_only;
            end else if ((r_state == ST_GAP) && (w_state_nx == ST_SETUP_L)) begin
                r_db <= r_lo;
            end
        end
    end

    assign e        = r_e;
    assign rs       = r_rs;
    assign db       = r_db;
    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/hd44780_byte_tx.md
Name: hd44780_byte_tx

Overview:
- Byte-level transmitter for the HD44780 LCD driver in 4-bit bus mode.
- Upstream producers (init sequencer, text buffer) supply one byte plus an RS flag over a valid/ready handshake.
- The block splits each byte into high and low nibbles, generates E with setup, pulse-width and hold timing, then enforces the post-command execution wait.
- Drives the LCD pins e, rs and db[3:0] directly; RW is tied low externally.

Parameters:
- T_SETUP, 2, cycles rs/db are stable before E rises (legal 1..255).
- T_EPW, 12, cycles E is held high per nibble (legal 1..255).
- T_HOLD, 2, cycles rs/db are held after E falls (legal 1..255).
- T_GAP, 2, idle cycles between high-nibble hold and low-nibble setup (legal 1..255).
- T_WAIT, 2000, post-transfer execution wait in cycles (legal 1..2^20-1).
- T_LONG, 82000, post-transfer wait for clear/home commands; used only with the optional feature (legal 1..2^20-1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; asynchronous, active-low.
- in_valid, input, 1, upstream byte valid.
- in_ready, output, 1, block can accept a byte.
- in_data, input, 8, byte to send.
- in_rs, input, 1, 0 = command, 1 = data.
- in_nibble_only, input, 1, send the high nibble only (init 0x3/0x2 writes).
- e, output, 1, LCD enable strobe.
- rs, output, 1, LCD register select.
- db, output, 4, LCD data bus DB7..DB4.
- busy, output, 1, high whenever the block is not in IDLE.

Behaviour:
- Reset (async, rst=0): state IDLE; e=0, rs=0, db=0, busy=0, in_ready=1 after release. Reset mid-transfer drops e to 0 immediately and the byte is abandoned.
- in_ready = (state==IDLE); combinational from state only, never from in_valid.
- Transfer is accepted on a rising clk edge with in_valid && in_ready. That edge latches data, rs and nibble_only, and enters SETUP_H. Inputs are don't-care afterwards.
- States and durations (each state lasts exactly its parameter in cycles; a single delay counter is loaded on entry):
  - IDLE
  - SETUP_H (T_SETUP) -> EHI_H (T_EPW) -> HOLD_H (T_HOLD)
  - If nibble_only, go to WAIT; otherwise -> GAP (T_GAP) -> SETUP_L (T_SETUP) -> EHI_L (T_EPW) -> HOLD_L (T_HOLD)
  - WAIT (wait count) -> IDLE
- db = data[7:4] from SETUP_H through GAP; data[3:0] from SETUP_L through WAIT. rs = latched rs for the whole transfer.
- e = 1 only in EHI_H/EHI_L; registered, glitch-free.
- In IDLE, rs/db hold their last driven values; only reset clears them.
- Latency, acceptance edge to in_ready=1 with defaults: full byte 2034 cycles; nibble_only 2016 cycles.
- Back-to-back: a byte can be accepted on the same edge the block returns to IDLE+1 (one IDLE cycle minimum).
- Counter: down-counter, 20 bits. State advances when the count is 1 and loads the next duration.
- A parameter value of 0 is illegal and is flagged by an elaboration-time check.

Optional Feature:
- Macro: HD44780_LONG_CMD_DELAY_EN
- Defined: if latched rs=0 and data is 8'h01, 8'h02 or 8'h03 (clear/home), WAIT lasts T_LONG. Default full-byte latency becomes 82034.
- Undefined: WAIT always lasts T_WAIT; T_LONG is unused.

Decomposition:
- Shared include hd44780_defs.vh holds:
  - state encodings (4-bit)
  - CMD_CLEAR=8'h01, CMD_HOME=8'h02
  - default timing constants
  - DB width 4
- One sub-module: hd44780_delay, a loadable 20-bit down-counter with a done flag, also reusable by the existing ROM sequencer.

Test Plan:
- Reset mid-EHI_H, then release -> e=0 immediately while rst=0; in_ready=1 one cycle after release; rs=0, db=0.
- Send in_data=8'h48, in_rs=1 -> two E pulses of 12 cycles each; db=4'h4 during the first, 4'h8 during the second; rs=1 throughout; in_ready=1 at acceptance+2034.
- Send 8'h30, in_nibble_only=1, in_rs=0 -> exactly one E pulse with db=4'h3; in_ready at +2016.
- in_valid held high with 3 queued bytes -> each accepted exactly once; no E pulse overlaps; inter-acceptance spacing 2035 cycles.
- in_valid toggling and in_data changing during a transfer -> outputs unaffected; no second acceptance while busy=1.
- With HD44780_LONG_CMD_DELAY_EN: 8'h01 rs=0 -> in_ready at +82034; 8'h01 rs=1 -> +2034. Without the macro, both cases -> +2034.
